// File: rtl/axil_master_arbiter.sv
// Shares one AXI-Lite master command port among NUM_REQ requesters, one transaction in flight.
// Latency: accept -> m_*_valid 1 cycle; master done -> resp_valid 1 cycle; accept spacing done-cycle + 2.
// Backpressure: req_ready only in IDLE; m_*_valid held until m_*_ready. Option macro: AXIL_ARB_FIXED_PRIO_EN.
module axil_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                  resp_valid,
  output logic [AXI_DATA_WIDTH-1:0]           resp_rdata,
  output logic [1:0]                          resp_error,
  output logic                                m_wr_valid,
  output logic [AXI_ADDR_WIDTH-1:0]           m_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0]           m_wr_data,
  input  logic                                m_wr_ready,
  input  logic                                m_wr_done,
  input  logic [1:0]                          m_wr_error,
  output logic                                m_rd_valid,
  output logic [AXI_ADDR_WIDTH-1:0]           m_rd_addr,
  input  logic                                m_rd_ready,
  input  logic                                m_rd_done,
  input  logic [1:0]                          m_rd_error,
  input  logic [AXI_DATA_WIDTH-1:0]           m_rd_data
);

  localparam int AW   = AXI_ADDR_WIDTH;
  localparam int DW   = AXI_DATA_WIDTH;
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDXW-1:0]    grant_q, grant_d;
  logic               wr_q, wr_d;
  logic               m_wr_valid_q, m_wr_valid_d;
  logic               m_rd_valid_q, m_rd_valid_d;
  logic [AW-1:0]      m_wr_addr_q, m_wr_addr_d;
  logic [AW-1:0]      m_rd_addr_q, m_rd_addr_d;
  logic [DW-1:0]      m_wr_data_q, m_wr_data_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [DW-1:0]      resp_rdata_q, resp_rdata_d;
  logic [1:0]         resp_error_q, resp_error_d;
`ifndef AXIL_ARB_FIXED_PRIO_EN
  logic [IDXW-1:0]    rr_ptr_q, rr_ptr_d;
`endif

  logic               win_vld;
  int                 win_int;

  // Pick the winning requester: lowest index (fixed) or first after rr_ptr (round-robin).
  always_comb begin
    int cand;
    win_vld = 1'b0;
    win_int = 0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = (int'(rr_ptr_q) + 1 + k) % NUM_REQ;
`endif
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_int = cand;
      end
    end
  end

  // Accept is combinational and only offered while idle.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && win_vld) req_ready = NUM_REQ'(1) << win_int;
  end

  // Transaction sequencing: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    m_wr_valid_d = m_wr_valid_q;
    m_rd_valid_d = m_rd_valid_q;
    m_wr_addr_d  = m_wr_addr_q;
    m_rd_addr_d  = m_rd_addr_q;
    m_wr_data_d  = m_wr_data_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
`ifndef AXIL_ARB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = IDXW'(win_int);
          wr_d    = req_write[win_int];
          if (req_write[win_int]) begin
            m_wr_valid_d = 1'b1;
            m_wr_addr_d  = req_addr[win_int*AW +: AW];
            m_wr_data_d  = req_wdata[win_int*DW +: DW];
          end else begin
            m_rd_valid_d = 1'b1;
            m_rd_addr_d  = req_addr[win_int*AW +: AW];
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wr_q ? m_wr_ready : m_rd_ready) begin
          m_wr_valid_d = 1'b0;
          m_rd_valid_d = 1'b0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        // Only the channel that carried the command can complete it.
        if (wr_q ? m_wr_done : m_rd_done) begin
          resp_error_d = wr_q ? m_wr_error : m_rd_error;
          if (!wr_q) resp_rdata_d = m_rd_data;
          resp_valid_d = NUM_REQ'(1) << grant_q;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid_d = '0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
        rr_ptr_d     = grant_q;
`endif
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      wr_q         <= 1'b0;
      m_wr_valid_q <= 1'b0;
      m_rd_valid_q <= 1'b0;
      m_wr_addr_q  <= '0;
      m_rd_addr_q  <= '0;
      m_wr_data_q  <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_error_q <= '0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= IDXW'(NUM_REQ - 1);
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      m_wr_valid_q <= m_wr_valid_d;
      m_rd_valid_q <= m_rd_valid_d;
      m_wr_addr_q  <= m_wr_addr_d;
      m_rd_addr_q  <= m_rd_addr_d;
      m_wr_data_q  <= m_wr_data_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign m_wr_valid = m_wr_valid_q;
  assign m_rd_valid = m_rd_valid_q;
  assign m_wr_addr  = m_wr_addr_q;
  assign m_rd_addr  = m_rd_addr_q;
  assign m_wr_data  = m_wr_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter: reset, single write/read, round-robin, stall, mid-reset.
// Inputs driven and outputs sampled on the falling clock edge.
// Fixed-priority scenario is compiled in when AXIL_ARB_FIXED_PRIO_EN is defined.
module tb_axil_master_arbiter;

  logic         aclk;
  logic         aresetn;
  logic [3:0]   req_valid, req_ready, req_write, resp_valid;
  logic [127:0] req_addr, req_wdata;
  logic [31:0]  resp_rdata, m_wr_addr, m_wr_data, m_rd_addr, m_rd_data;
  logic [1:0]   resp_error, m_wr_error, m_rd_error;
  logic         m_wr_valid, m_wr_ready, m_wr_done, m_rd_valid, m_rd_ready, m_rd_done;

  int n_cmp = 0;
  int n_err = 0;

  axil_master_arbiter #(.NUM_REQ(4), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .m_wr_valid(m_wr_valid), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .m_wr_ready(m_wr_ready), .m_wr_done(m_wr_done), .m_wr_error(m_wr_error),
    .m_rd_valid(m_rd_valid), .m_rd_addr(m_rd_addr),
    .m_rd_ready(m_rd_ready), .m_rd_done(m_rd_done), .m_rd_error(m_rd_error),
    .m_rd_data(m_rd_data)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(negedge aclk);
  endtask

  // Master-side stimulus from ISSUE: one ready cycle, then one done cycle. Returns in RESP.
  task automatic complete(input logic wr, input logic [31:0] rdata, input logic [1:0] err);
    if (wr) m_wr_ready = 1'b1; else m_rd_ready = 1'b1;
    step();
    m_wr_ready = 1'b0;
    m_rd_ready = 1'b0;
    if (wr) begin
      m_wr_done = 1'b1; m_wr_error = err;
    end else begin
      m_rd_done = 1'b1; m_rd_error = err; m_rd_data = rdata;
    end
    step();
    m_wr_done = 1'b0;
    m_rd_done = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) step();
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
    n_cmp++; if (resp_valid !== 4'b0) begin n_err++; $display("FAIL rst_resp_valid got=%b exp=0000", resp_valid); end
    n_cmp++; if ({m_wr_valid, m_rd_valid} !== 2'b00) begin n_err++; $display("FAIL rst_m_valid got=%b exp=00", {m_wr_valid, m_rd_valid}); end
    n_cmp++; if ({m_wr_addr, m_wr_data, m_rd_addr} !== 96'h0) begin n_err++; $display("FAIL rst_m_addr_data got=%h exp=0", {m_wr_addr, m_wr_data, m_rd_addr}); end
    n_cmp++; if ({resp_rdata, resp_error} !== 34'h0) begin n_err++; $display("FAIL rst_resp_data got=%h exp=0", {resp_rdata, resp_error}); end
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    req_write = 4'b0100;
    req_addr[64 +: 32]  = 32'h0000_0010;
    req_wdata[64 +: 32] = 32'hDEAD_BEEF;
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wr_req_ready got=%b exp=0100", req_ready); end
    step();
    req_valid = 4'b0;
    n_cmp++; if ({m_wr_valid, m_rd_valid, req_ready} !== 6'b10_0000) begin n_err++; $display("FAIL wr_issue_valid got=%b exp=100000", {m_wr_valid, m_rd_valid, req_ready}); end
    repeat (2) begin
      n_cmp++; if ({m_wr_valid, m_wr_addr, m_wr_data} !== {1'b1, 32'h10, 32'hDEADBEEF}) begin n_err++; $display("FAIL wr_issue_hold got=%b/%h/%h exp=1/00000010/deadbeef", m_wr_valid, m_wr_addr, m_wr_data); end
      step();
    end
    m_wr_ready = 1'b1;
    step();
    m_wr_ready = 1'b0;
    n_cmp++; if (m_wr_valid !== 1'b0) begin n_err++; $display("FAIL wr_valid_drop got=%b exp=0", m_wr_valid); end
    m_wr_done = 1'b1; m_wr_error = 2'b00;
    step();
    m_wr_done = 1'b0;
    n_cmp++; if ({resp_valid, resp_error} !== 6'b0100_00) begin n_err++; $display("FAIL wr_resp got=%b/%b exp=0100/00", resp_valid, resp_error); end
    step();
    n_cmp++; if (resp_valid !== 4'b0) begin n_err++; $display("FAIL wr_resp_pulse got=%b exp=0000", resp_valid); end
  endtask

  task automatic test_single_read();
    req_write = 4'b0000;
    req_addr[32 +: 32] = 32'h0000_0024;
    req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rd_req_ready got=%b exp=0010", req_ready); end
    step();
    req_valid = 4'b0;
    n_cmp++; if ({m_rd_valid, m_wr_valid, m_rd_addr} !== {2'b10, 32'h24}) begin n_err++; $display("FAIL rd_issue got=%b%b/%h exp=10/00000024", m_rd_valid, m_wr_valid, m_rd_addr); end
    complete(1'b0, 32'h1234_5678, 2'b10);
    n_cmp++; if (resp_valid !== 4'b0010) begin n_err++; $display("FAIL rd_resp_valid got=%b exp=0010", resp_valid); end
    n_cmp++; if ({resp_rdata, resp_error} !== {32'h12345678, 2'b10}) begin n_err++; $display("FAIL rd_resp_data got=%h/%b exp=12345678/10", resp_rdata, resp_error); end
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    req_write = 4'b0000;
    for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h100 + 32'(i*4);
    req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp = 4'b0001 << (t % 4);
      #1;
      n_cmp++; if (req_ready !== exp) begin n_err++; $display("FAIL rr_grant%0d got=%b exp=%b", t, req_ready, exp); end
      step();
      n_cmp++; if (m_rd_addr !== 32'h100 + 32'((t % 4) * 4)) begin n_err++; $display("FAIL rr_addr%0d got=%h exp=%h", t, m_rd_addr, 32'h100 + 32'((t % 4) * 4)); end
      complete(1'b0, 32'hA000 + 32'(t), 2'b00);
      n_cmp++; if ({resp_valid, req_ready} !== {exp, 4'b0}) begin n_err++; $display("FAIL rr_resp%0d got=%b/%b exp=%b/0000", t, resp_valid, req_ready, exp); end
      n_cmp++; if (resp_rdata !== 32'hA000 + 32'(t)) begin n_err++; $display("FAIL rr_rdata%0d got=%h exp=%h", t, resp_rdata, 32'hA000 + 32'(t)); end
      step();
    end
    req_valid = 4'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] rdata_before;
    rdata_before = resp_rdata;
    req_write = 4'b1000;
    req_addr[96 +: 32]  = 32'h0000_0040;
    req_wdata[96 +: 32] = 32'hCAFE_F00D;
    req_addr[0 +: 32]   = 32'h0000_0200;
    req_valid = 4'b1000;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_req_ready got=%b exp=1000", req_ready); end
    step();
    req_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++; if ({m_wr_valid, m_wr_addr, m_wr_data, req_ready} !== {1'b1, 32'h40, 32'hCAFEF00D, 4'b0}) begin
        n_err++; $display("FAIL bp_stall%0d got=%b/%h/%h/%b exp=1/00000040/cafef00d/0000", c, m_wr_valid, m_wr_addr, m_wr_data, req_ready);
      end
      step();
    end
    complete(1'b1, 32'h0, 2'b00);
    n_cmp++; if ({resp_valid, req_ready} !== 8'b1000_0000) begin n_err++; $display("FAIL bp_resp got=%b/%b exp=1000/0000", resp_valid, req_ready); end
    n_cmp++; if (resp_rdata !== rdata_before || rdata_before !== 32'hA007) begin n_err++; $display("FAIL bp_rdata_kept got=%h exp=0000a007", resp_rdata); end
    step();
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_next_grant got=%b exp=0001", req_ready); end
    step();
    req_valid = 4'b0;
    n_cmp++; if ({m_rd_valid, m_rd_addr} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL bp_next_issue got=%b/%h exp=1/00000200", m_rd_valid, m_rd_addr); end
    complete(1'b0, 32'h5555_AAAA, 2'b00);
    n_cmp++; if (resp_valid !== 4'b0001) begin n_err++; $display("FAIL bp_next_resp got=%b exp=0001", resp_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    req_write = 4'b0000;
    req_addr[64 +: 32] = 32'h0000_0080;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0;
    m_rd_ready = 1'b1;
    step();
    m_rd_ready = 1'b0;
    aresetn = 1'b0;
    step();
    n_cmp++; if ({req_ready, resp_valid, m_rd_valid, m_wr_valid} !== 10'b0) begin n_err++; $display("FAIL mid_rst_ctrl got=%b exp=0", {req_ready, resp_valid, m_rd_valid, m_wr_valid}); end
    n_cmp++; if ({m_rd_addr, m_wr_addr, m_wr_data, resp_rdata, resp_error} !== 130'h0) begin n_err++; $display("FAIL mid_rst_data got=%h exp=0", {m_rd_addr, m_wr_addr, m_wr_data, resp_rdata, resp_error}); end
    aresetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (resp_valid !== 4'b0) begin n_err++; $display("FAIL mid_rst_stray%0d got=%b exp=0000", c, resp_valid); end
    end
    req_valid = 4'b1001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_rst_first got=%b exp=0001", req_ready); end
    step();
    req_valid = 4'b1000;
    complete(1'b0, 32'h1, 2'b00);
    step();
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL mid_rst_second got=%b exp=1000", req_ready); end
    step();
    req_valid = 4'b0;
    complete(1'b0, 32'h2, 2'b00);
    step();
  endtask

`ifdef AXIL_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    req_write = 4'b0000;
    req_valid = 4'b1001;
    for (int t = 0; t < 3; t++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL fp_grant%0d got=%b exp=0001", t, req_ready); end
      step();
      complete(1'b0, 32'h3, 2'b00);
      step();
    end
    req_valid = 4'b1000;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL fp_low got=%b exp=1000", req_ready); end
    step();
    req_valid = 4'b0;
    complete(1'b0, 32'h4, 2'b00);
    step();
  endtask
`endif

  initial begin
    aresetn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    m_wr_ready = 1'b0; m_wr_done = 1'b0; m_wr_error = 2'b00;
    m_rd_ready = 1'b0; m_rd_done = 1'b0; m_rd_error = 2'b00; m_rd_data = '0;
    test_reset();
    test_single_write();
    test_single_read();
`ifndef AXIL_ARB_FIXED_PRIO_EN
    test_round_robin();
`else
    test_fixed_prio();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    m_rd_data = 32'hA007;
    req_addr[0 +: 32] = 32'h0;
    complete(1'b0, 32'hA007, 2'b00);
    step();
`endif
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

endmodule
